// File: rtl/sun_pll_divn_lock.sv
// Integer-N feedback divider with reference-period measurement and lock qualification.
// States: IDLE = disabled | ARM = discard first measurement | TRACK = counting good periods | LOCK = locked
module sun_pll_divn_lock #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 32,
    parameter int LOCK_CNT    = 16,
    parameter int TOL         = 2
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV_N,
    input  logic             CK_REF,
    output logic             CK_FB,
    output logic             LOCKED,
    output logic             LOCK_LOST,
    output logic [DIV_W+1:0] PERIOD,
    output logic             PERIOD_VLD
);

    localparam int PW = DIV_W + 2;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO_D = DIV_W'(2);
    localparam logic [PW-1:0]    PMAX  = '1;
    localparam logic [PW-1:0]    ONE_P = PW'(1);
    localparam logic [PW-1:0]    TOL_P = PW'(TOL);
    localparam logic [GW-1:0]    ONE_G = GW'(1);
    localparam logic [GW-1:0]    LCK_G = GW'(LOCK_CNT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_TRACK, S_LOCK} state_t;

    logic [DIV_W-1:0] cnt, cnt_next, n_act, n_next, n_req;
    logic             reload, ratio_chg, fb_next;

    always_comb begin
        n_req     = (DIV_N < TWO_D) ? TWO_D : DIV_N;
        reload    = EN && (cnt == '0);
        ratio_chg = reload && (n_req != n_act);
        n_next    = reload ? n_req : n_act;
        if (!EN)
            cnt_next = '0;
        else if (reload)
            cnt_next = n_req - ONE_D;
        else
            cnt_next = cnt - ONE_D;
        fb_next = EN && (cnt_next >= (n_next >> 1));
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            cnt   <= '0;
            n_act <= DIV_W'(DIV_DEFAULT);
            CK_FB <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            n_act <= n_next;
            CK_FB <= fb_next;
        end
    end

    logic          ref_s1, ref_s2, ref_s3, ref_rise;
    logic [PW-1:0] pcnt;

    always_ff @(posedge CK) begin
        if (RST) begin
            ref_s1     <= 1'b0;
            ref_s2     <= 1'b0;
            ref_s3     <= 1'b0;
            ref_rise   <= 1'b0;
            pcnt       <= '0;
            PERIOD     <= '0;
            PERIOD_VLD <= 1'b0;
        end else begin
            ref_s1     <= CK_REF;
            ref_s2     <= ref_s1;
            ref_s3     <= ref_s2;
            ref_rise   <= ref_s2 & ~ref_s3;
            PERIOD_VLD <= ref_rise;
            if (ref_rise) begin
                PERIOD <= pcnt;
                pcnt   <= ONE_P;
            end else if (pcnt != PMAX) begin
                pcnt <= pcnt + ONE_P;
            end
        end
    end

    logic [PW-1:0] n_ext, diff;
    logic          good, meas, sat_evt;

    always_comb begin
        n_ext   = {2'b00, n_act};
        diff    = (PERIOD >= n_ext) ? (PERIOD - n_ext) : (n_ext - PERIOD);
        good    = (PERIOD != PMAX) && (diff <= TOL_P);
        meas    = PERIOD_VLD;
        // a missing reference counts as a bad measurement exactly once, when pcnt pins
        sat_evt = !ref_rise && (pcnt == PMAX - ONE_P);
    end

    state_t        state, state_next;
    logic [GW-1:0] gcnt, gcnt_next;

    always_comb begin
        state_next = state;
        gcnt_next  = gcnt;
        if (!EN) begin
            state_next = S_IDLE;
            gcnt_next  = '0;
        end else if (ratio_chg) begin
            state_next = S_ARM;
            gcnt_next  = '0;
        end else begin
            case (state)
                S_IDLE: state_next = S_ARM;
                S_ARM: begin
                    if (meas) begin
                        gcnt_next  = '0;
                        state_next = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (meas) begin
                        if (good) begin
                            gcnt_next = gcnt + ONE_G;
                            if (gcnt_next == LCK_G)
                                state_next = S_LOCK;
                        end else begin
                            gcnt_next = '0;
                        end
                    end
                end
                S_LOCK: begin
                    if ((meas && !good) || sat_evt) begin
                        state_next = S_TRACK;
                        gcnt_next  = '0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_IDLE;
            gcnt      <= '0;
            LOCKED    <= 1'b0;
            LOCK_LOST <= 1'b0;
        end else begin
            state     <= state_next;
            gcnt      <= gcnt_next;
            LOCKED    <= (state_next == S_LOCK);
            LOCK_LOST <= LOCKED && (state_next != S_LOCK);
        end
    end

endmodule

// File: doc/sun_pll_divn_lock.md
# sun_pll_divn_lock

Programmable integer-N feedback divider with integrated digital lock detector for the SUN_PLL family. It replaces the fixed divide-by-32 ripple divider with a synchronous down-counter whose ratio can be changed at runtime without glitches on the feedback clock. It also measures the reference period in VCO cycles and reports a qualified LOCKED flag. It sits between the ring oscillator output (CK) and the PFD feedback input (CK_FB).

## Interface
- DIV_W, 8: width of divide ratio.
- DIV_DEFAULT, 32: ratio used after reset until the first reload.
- LOCK_CNT, 16: number of consecutive good reference periods required to assert LOCKED.
- TOL, 2: allowed |measured period − ratio| in CK cycles.

- CK  in  1  VCO clock. This is the only clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable (PWRUP_1V8 domain, already synchronous to CK).
- DIV_N  in  DIV_W  requested divide ratio. Values 0 and 1 are clamped to 2.
- CK_REF  in  1  reference clock, asynchronous to CK. It is synchronised internally.
- CK_FB  out  1  divided clock to the PFD. It is registered.
- LOCKED  out  1  lock indication.
- LOCK_LOST  out  1  one-cycle pulse when LOCKED falls.
- PERIOD  out  DIV_W+2  last measured reference period in CK cycles.
- PERIOD_VLD  out  1  one-cycle pulse when PERIOD updates.

## Operation
- Reset values: cnt=0, n_act=DIV_DEFAULT, CK_FB=0, LOCKED=0, LOCK_LOST=0, PERIOD=0, PERIOD_VLD=0, pcnt=0, gcnt=0, FSM=IDLE.
- **Divider** (EN=1):
  - When cnt==0: n_act←clamp(DIV_N) and cnt←n_act_new−1.
  - Otherwise: cnt←cnt−1.
  - CK_FB_next = (cnt_next ≥ n_act_next>>1). CK_FB is therefore high for ceil(N/2) cycles and low for floor(N/2) cycles, and the period is exactly N.
  - DIV_N is sampled only at reload, so no runt pulses occur.
- **Divider** (EN=0): cnt←0, CK_FB←0, n_act is held.
- **Ref sampling:** 2-flop synchroniser, then an edge register. ref_rise is a pulse on a synchronised 0→1 transition.
- **Period counter:**
  - On ref_rise: PERIOD←pcnt, PERIOD_VLD←1, pcnt←1.
  - Otherwise: pcnt←pcnt+1, saturating at all-ones.
  - good = (PERIOD not saturated) and |PERIOD−n_act| ≤ TOL. The arithmetic is done at DIV_W+2 bits, unsigned, with the larger minus the smaller.
- **FSM:**
  - IDLE: LOCKED=0. On EN=1 → ARM.
  - ARM: on the first ref_rise, discard the measurement. gcnt←0, → TRACK.
  - TRACK, on each measurement:
    - good: gcnt←gcnt+1. When gcnt reaches LOCK_CNT → LOCKED state, LOCKED←1.
    - bad: gcnt←0.
  - LOCKED state:
    - Bad measurement: LOCKED←0, LOCK_LOST pulse, gcnt←0, → TRACK.
    - pcnt reaching saturation (reference missing) is treated as a bad measurement in the cycle it saturates.
  - From any state, EN=0 → IDLE, LOCKED←0. LOCK_LOST pulses if LOCKED was 1.
  - Ratio change: a reload with new n_act ≠ old n_act forces → ARM and gcnt←0. LOCK_LOST pulses if LOCKED was 1.
- **Simultaneous events:**
  - A ratio-change reload and a measurement in the same cycle: the ratio change wins and the measurement is discarded.
  - RST overrides everything.

## Timing
- CK_FB's first rising edge occurs on the first CK edge with EN=1. Latency from EN to CK_FB is 1 cycle.
- ref_rise is produced 3 CK cycles after the CK_REF rising edge. PERIOD and PERIOD_VLD are registered 1 cycle later.
- LOCKED rises on the PERIOD_VLD cycle of the LOCK_CNT-th consecutive good measurement. Evaluation is combinational on the new PERIOD, registered in the same cycle as PERIOD_VLD+1.
- A DIV_N change takes effect at the next cnt==0. Worst-case delay is the old N cycles.
- LOCK_LOST is exactly 1 cycle wide and coincides with the first cycle of LOCKED=0.

## Test plan
- **Reset and static divide:** RST, then EN=1 with DIV_N=5 → CK_FB pattern 1,1,1,0,0 repeating, with the first high on cycle 1. Also check DIV_N=0 → divide by 2.
- **Lock acquisition:** DIV_N=32, CK_REF period = 32 CK cycles → LOCKED=1 after ARM plus 16 good periods, and PERIOD=32.
- **Tolerance boundary:** CK_REF period 34 → locks. Period 35 → never locks, and gcnt is repeatedly cleared.
- **Loss of lock:** while locked, stop CK_REF → LOCK_LOST pulses once when pcnt saturates at 1023, and LOCKED=0. Restart CK_REF at period 32 → relock after ARM plus 16 periods.
- **Glitch-free ratio change:** locked at 32, change DIV_N to 40 mid-count → the current 32-cycle period completes untruncated, the next period is 40, and LOCK_LOST pulses. With CK_REF at 40 the block relocks.
- **EN drop and reset mid-operation:** EN=0 while locked → CK_FB=0 next cycle, LOCKED=0, and LOCK_LOST pulses. RST mid-count → all outputs return to their reset values on the next edge.
